// File: rtl/uart_pkg.sv
// Encodings shared by the UART transmit framer, parity generator and receive deframer.
package uart_pkg;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    localparam logic LEN_7  = 1'b0;
    localparam logic LEN_8  = 1'b1;
    localparam logic STOP_1 = 1'b0;
    localparam logic STOP_2 = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic parity_enabled(input logic [1:0] pt);
        return !(pt == PAR_NONE0 || pt == PAR_NONE3);
    endfunction

    // Value the parity bit must carry for the given data.
    function automatic logic parity_bit(input logic [1:0] pt, input logic [7:0] d);
        return (pt == PAR_ODD) ? ~^d : ^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for asynchronous inputs; resets to 1 so an idle-high line
// does not look like a start bit while coming out of reset.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: oversampled start detection, 7/8 data bits LSB first,
// optional odd/even parity, 1/2 stop bits, one-clk data_valid with error flags.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tick,
    input  logic       rx_in,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       stop_error,
    output logic       rx_busy
);

    localparam int            TW   = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

    logic rx_s;

    rx_state_e     state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [1:0]    par_q, par_d;
    logic          stop_q, stop_d;
    logic          len_q, len_d;
    logic          perr_q, perr_d;
    logic          serr_q, serr_d;
    logic          armed_q, armed_d;
    logic [7:0]    dout_q, dout_d;
    logic          perr_out_q, perr_out_d;
    logic          serr_out_q, serr_out_d;
    logic          valid_q, valid_d;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_in),
        .q_o (rx_s)
    );

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        par_d      = par_q;
        stop_d     = stop_q;
        len_d      = len_q;
        perr_d     = perr_q;
        serr_d     = serr_q;
        dout_d     = dout_q;
        perr_out_d = perr_out_q;
        serr_out_d = serr_out_q;
        valid_d    = 1'b0;
        // A frame ending on a low stop bit (break) disarms start detection until
        // the line has been seen high again, so a held-low line yields one frame.
        armed_d    = armed_q | rx_s;
        if (s_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s && armed_q) begin
                        state_d = START;
                        tick_d  = '0;
                        par_d   = parity_type;
                        stop_d  = stop_bits;
                        len_d   = data_length;
                        perr_d  = 1'b0;
                        serr_d  = 1'b0;
                    end
                end
                START: begin
                    if (tick_q == HALF) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == LAST) begin
                        tick_d = '0;
                        // 7-bit frames shift in at bit 6 so bit 7 stays 0.
                        sh_d = (len_q == LEN_8) ? {rx_s, sh_q[7:1]} : {1'b0, rx_s, sh_q[6:1]};
                        if (bit_q == ((len_q == LEN_8) ? 3'd7 : 3'd6)) begin
                            bit_d   = '0;
                            state_d = parity_enabled(par_q) ? PARITY : STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (tick_q == LAST) begin
                        tick_d  = '0;
                        perr_d  = (rx_s != parity_bit(par_q, sh_q));
                        state_d = STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == LAST) begin
                        tick_d = '0;
                        serr_d = serr_q | ~rx_s;
                        if (bit_q == ((stop_q == STOP_2) ? 3'd1 : 3'd0)) begin
                            bit_d      = '0;
                            state_d    = IDLE;
                            valid_d    = 1'b1;
                            dout_d     = sh_q;
                            perr_out_d = perr_q;
                            serr_out_d = serr_q | ~rx_s;
                            armed_d    = rx_s;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            sh_q       <= '0;
            par_q      <= PAR_NONE0;
            stop_q     <= STOP_1;
            len_q      <= LEN_7;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            armed_q    <= 1'b1;
            dout_q     <= '0;
            perr_out_q <= 1'b0;
            serr_out_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            sh_q       <= sh_d;
            par_q      <= par_d;
            stop_q     <= stop_d;
            len_q      <= len_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            armed_q    <= armed_d;
            dout_q     <= dout_d;
            perr_out_q <= perr_out_d;
            serr_out_q <= serr_out_d;
            valid_q    <= valid_d;
        end
    end

    assign data_out     = dout_q;
    assign data_valid   = valid_q;
    assign parity_error = perr_out_q;
    assign stop_error   = serr_out_q;
    assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Randomized bench for uart_rx_deframer: frames are built bit by bit on rx_in and the
// received bytes/flags are compared with a frame-level reference model.
module tb_uart_rx_deframer;

    localparam int OS       = 16;
    localparam int TDIV     = 3;
    localparam int BIT_CLKS = OS * TDIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_tick;
    logic       rx_in;
    logic [1:0] parity_type;
    logic       stop_bits;
    logic       data_length;
    logic [7:0] data_out;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       rx_busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       se;
        logic       busy;
    } frm_t;

    int   nvec = 0;
    int   nerr = 0;
    int   wide_pulses = 0;
    frm_t got_q[$];
    frm_t exp_q[$];
    frm_t mon_f;
    logic prev_valid = 1'b0;

    uart_rx_deframer #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_tick       (s_tick),
        .rx_in        (rx_in),
        .parity_type  (parity_type),
        .stop_bits    (stop_bits),
        .data_length  (data_length),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .rx_busy      (rx_busy)
    );

    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (TDIV - 1) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    // Record every data_valid cycle, plus whether any pulse lasted more than one clk.
    always @(negedge clk) begin
        if (data_valid) begin
            mon_f = '{d: data_out, pe: parity_error, se: stop_error, busy: rx_busy};
            got_q.push_back(mon_f);
            if (prev_valid) wide_pulses++;
        end
        prev_valid = data_valid;
    end

    // Reference: what a receiver must report for one complete frame.
    function automatic frm_t model(input logic [7:0] d, input bit len8, input logic [1:0] pt,
                                   input bit two_stop, input bit pbit, input bit [1:0] sv);
        frm_t f;
        int   ones;
        f.d  = len8 ? d : {1'b0, d[6:0]};
        ones = $countones(f.d) + int'(pbit);
        f.pe = 1'b0;
        if (pt == 2'b01) f.pe = (ones % 2) != 1;
        if (pt == 2'b10) f.pe = (ones % 2) != 0;
        f.se   = !sv[0] || (two_stop && !sv[1]);
        f.busy = 1'b0;
        return f;
    endfunction

    function automatic string fstr(input frm_t f);
        return $sformatf("d=%h pe=%b se=%b busy=%b", f.d, f.pe, f.se, f.busy);
    endfunction

    // Drives one frame from a negedge; abort_after >= 0 stops driving after that many bits.
    task automatic send_frame(input logic [7:0] d, input bit len8, input logic [1:0] pt,
                              input bit two_stop, input bit pbit, input bit [1:0] sv,
                              input int abort_after, input bit scramble);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < (len8 ? 8 : 7); i++) bits.push_back(d[i]);
        if (pt == 2'b01 || pt == 2'b10) bits.push_back(pbit);
        bits.push_back(sv[0]);
        if (two_stop) bits.push_back(sv[1]);
        parity_type = pt;
        stop_bits   = two_stop;
        data_length = len8;
        if (abort_after < 0) exp_q.push_back(model(d, len8, pt, two_stop, pbit, sv));
        for (int i = 0; i < bits.size(); i++) begin
            if (abort_after >= 0 && i == abort_after) return;
            if (scramble && i == 1) begin
                parity_type = 2'($urandom_range(3));
                stop_bits   = 1'($urandom_range(1));
                data_length = 1'($urandom_range(1));
            end
            if (scramble && i == bits.size() - 1) begin
                parity_type = pt;
                stop_bits   = two_stop;
                data_length = len8;
            end
            rx_in = bits[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic idle_bits(input int n);
        rx_in = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_in = 1'b1; parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
        repeat (4) @(negedge clk);
        nvec++;
        if ({data_out, data_valid, parity_error, stop_error, rx_busy} !== 12'h000) begin
            nerr++;
            $display("FAIL reset_state: got out=%h v=%b pe=%b se=%b busy=%b, want all 0",
                     data_out, data_valid, parity_error, stop_error, rx_busy);
        end
        rst = 1'b0;
        idle_bits(2);
    endtask

    task automatic test_8n1;
        send_frame(8'hA5, 1, 2'b00, 0, 0, 2'b11, -1, 0);
        idle_bits(2);
        nvec++;
        if (got_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL 8n1_count: got %0d frames, want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            frm_t g = got_q.pop_front();
            frm_t e = exp_q.pop_front();
            nvec++;
            if (g !== e) begin nerr++; $display("FAIL 8n1_frame: got %s, want %s", fstr(g), fstr(e)); end
        end
        nvec++;
        if ({data_out, data_valid, rx_busy} !== {8'hA5, 2'b00}) begin
            nerr++;
            $display("FAIL 8n1_hold: got out=%h v=%b busy=%b, want out=a5 v=0 busy=0",
                     data_out, data_valid, rx_busy);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_7e2;
        send_frame(8'h35, 0, 2'b10, 1, 0, 2'b11, -1, 0);
        send_frame(8'h35, 0, 2'b10, 1, 1, 2'b11, -1, 0);
        send_frame(8'hB5, 0, 2'b10, 1, 1, 2'b11, -1, 0);
        idle_bits(1);
        nvec++;
        if (got_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL 7e2_count: got %0d frames, want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            frm_t g = got_q.pop_front();
            frm_t e = exp_q.pop_front();
            nvec++;
            if (g !== e) begin nerr++; $display("FAIL 7e2_frame: got %s, want %s", fstr(g), fstr(e)); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_8o1;
        send_frame(8'h00, 1, 2'b01, 0, 1, 2'b11, -1, 0);
        send_frame(8'hFF, 1, 2'b01, 0, 0, 2'b11, -1, 0);
        send_frame(8'hFF, 1, 2'b01, 0, 1, 2'b11, -1, 0);
        send_frame(8'h80, 1, 2'b11, 0, 0, 2'b11, -1, 0);
        idle_bits(1);
        nvec++;
        if (got_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL 8o1_count: got %0d frames, want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            frm_t g = got_q.pop_front();
            frm_t e = exp_q.pop_front();
            nvec++;
            if (g !== e) begin nerr++; $display("FAIL 8o1_frame: got %s, want %s", fstr(g), fstr(e)); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_break;
        parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
        exp_q.push_back(model(8'h00, 1, 2'b00, 0, 0, 2'b00));
        rx_in = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
        idle_bits(3);
        nvec++;
        if (got_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL break_count: got %0d frames, want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            frm_t g = got_q.pop_front();
            frm_t e = exp_q.pop_front();
            nvec++;
            if (g !== e) begin nerr++; $display("FAIL break_frame: got %s, want %s", fstr(g), fstr(e)); end
        end
        nvec++;
        if (rx_busy !== 1'b0) begin nerr++; $display("FAIL break_busy: got %b, want 0", rx_busy); end
        exp_q.delete(); got_q.delete();
        send_frame(8'h5C, 1, 2'b00, 0, 0, 2'b11, -1, 0);
        idle_bits(1);
        nvec++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            nerr++;
            $display("FAIL break_recover: got %0d frames (first %s), want 1 frame %s",
                     got_q.size(), (got_q.size() > 0) ? fstr(got_q[0]) : "none", fstr(exp_q[0]));
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_glitch_back_to_back;
        parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
        rx_in = 1'b0;
        repeat (4 * TDIV) @(negedge clk);
        rx_in = 1'b1;
        repeat (8 * TDIV) @(negedge clk);
        nvec++;
        if (rx_busy !== 1'b0 || got_q.size() != 0) begin
            nerr++;
            $display("FAIL glitch: got busy=%b frames=%0d, want busy=0 frames=0", rx_busy, got_q.size());
        end
        idle_bits(1);
        send_frame(8'h3C, 1, 2'b00, 0, 0, 2'b11, -1, 0);
        send_frame(8'hC3, 1, 2'b00, 0, 0, 2'b11, -1, 0);
        idle_bits(1);
        nvec++;
        if (got_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL b2b_count: got %0d frames, want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            frm_t g = got_q.pop_front();
            frm_t e = exp_q.pop_front();
            nvec++;
            if (g !== e) begin nerr++; $display("FAIL b2b_frame: got %s, want %s", fstr(g), fstr(e)); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        send_frame(8'h5A, 1, 2'b00, 0, 0, 2'b11, 4, 0);
        rst = 1'b1;
        #1;
        nvec++;
        if ({data_out, data_valid, parity_error, stop_error, rx_busy} !== 12'h000) begin
            nerr++;
            $display("FAIL midreset_state: got out=%h v=%b pe=%b se=%b busy=%b, want all 0",
                     data_out, data_valid, parity_error, stop_error, rx_busy);
        end
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        idle_bits(2);
        send_frame(8'h81, 1, 2'b00, 0, 0, 2'b11, -1, 0);
        idle_bits(1);
        nvec++;
        if (got_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL midreset_count: got %0d frames, want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            frm_t g = got_q.pop_front();
            frm_t e = exp_q.pop_front();
            nvec++;
            if (g !== e) begin nerr++; $display("FAIL midreset_frame: got %s, want %s", fstr(g), fstr(e)); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random;
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d        = 8'($urandom_range(255));
            bit         len8     = 1'($urandom_range(1));
            logic [1:0] pt       = 2'($urandom_range(3));
            bit         two_stop = 1'($urandom_range(1));
            int         ones     = $countones(len8 ? d : {1'b0, d[6:0]});
            bit         pbit     = (pt == 2'b01) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            bit [1:0]   sv       = 2'b11;
            int         gap      = $urandom_range(2);
            if ($urandom_range(9) < 3) pbit = ~pbit;
            if ($urandom_range(9) < 2) sv[0] = 1'b0;
            if ($urandom_range(9) < 2) sv[1] = 1'b0;
            if ((two_stop ? sv[1] : sv[0]) == 1'b0 && gap == 0) gap = 1;
            send_frame(d, len8, pt, two_stop, pbit, sv, -1, 1'($urandom_range(1)));
            if (gap > 0) idle_bits(gap);
        end
        idle_bits(1);
        nvec++;
        if (got_q.size() != exp_q.size()) begin
            nerr++; $display("FAIL rand_count: got %0d frames, want %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            frm_t g = got_q.pop_front();
            frm_t e = exp_q.pop_front();
            nvec++;
            if (g !== e) begin nerr++; $display("FAIL rand_frame: got %s, want %s", fstr(g), fstr(e)); end
        end
        nvec++;
        if (wide_pulses != 0) begin
            nerr++; $display("FAIL valid_width: got %0d multi-cycle pulses, want 0", wide_pulses);
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_7e2();
        test_8o1();
        test_break();
        test_glitch_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #700000;
        nerr++;
        $display("FAIL timeout: bench still running at %0t, want finished", $time);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
